dot_vec_pipe: RTL and testbench

- Parametrised, pipelined fixed-point dot product engine; next generation of the 3-element dot block.
- Consumes one pair of N-element signed Qm.Q_BITS vectors per cycle from upstream first-word-fall-through (FWFT) FIFOs and produces one scalar per vector pair.
- The result goes into an internal FWFT output buffer with credit-based backpressure.
- Sits between fifo_array sources and downstream ray/geometry math stages.

---
 rtl/dot_vec_pipe.sv | 156 +++++++++++++++
 tb/tb_dot_vec_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dot_vec_pipe.sv
// dot_vec_pipe: pipelined signed fixed-point dot product of two VEC_LEN vectors.
// Inputs are popped from FWFT sources. Results land in a small FWFT output buffer.
// Issue is credit-gated: buffer occupancy plus in-flight stages never exceed OUT_DEPTH.
module dot_vec_pipe #(
  parameter int VEC_LEN    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int Q_BITS     = 10,
  parameter int OUT_DEPTH  = 4,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]    x,
  input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]    y,
  input  logic                                  in_empty,
  output logic                                  in_rd_en,
  output logic [DATA_WIDTH-1:0]                 out,
  output logic                                  out_empty,
  input  logic                                  out_rd_en,
  output logic [$clog2(OUT_DEPTH):0]            out_count,
  input  logic                                  clear_ovf,
  output logic                                  ovf
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(VEC_LEN);
  localparam int ACC_W  = SUM_W + 1;
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic signed [ACC_W-1:0] RND_INC =
    (ROUND != 0 && Q_BITS > 0) ? (ACC_W'(1) << (Q_BITS > 0 ? Q_BITS - 1 : 0)) : '0;
  localparam logic signed [ACC_W-1:0] MAX_V =
    $signed({{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}});
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  // Optional half-up rounding, then arithmetic shift back to Q_BITS fraction.
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [SUM_W-1:0] s);
    logic signed [ACC_W-1:0] a;
    a = ACC_W'(s) + RND_INC;
    return a >>> Q_BITS;
  endfunction

  // True when the shifted value does not fit the signed result range.
  function automatic logic out_of_range(input logic signed [ACC_W-1:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  // Clamp to the nearest bound (SATURATE) or keep the low bits (wrap).
  function automatic logic [DATA_WIDTH-1:0] fit_result(input logic signed [ACC_W-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    r = v[DATA_WIDTH-1:0];
    if (SATURATE != 0 && out_of_range(v))
      r = v[ACC_W-1] ? MIN_V[DATA_WIDTH-1:0] : MAX_V[DATA_WIDTH-1:0];
    return r;
  endfunction

  logic signed [PROD_W-1:0]    prod_p1_d [VEC_LEN];
  logic signed [PROD_W-1:0]    prod_p1_q [VEC_LEN];
  logic signed [SUM_W-1:0]     sum_p2_d, sum_p2_q;
  logic signed [ACC_W-1:0]     acc_p3;
  logic [DATA_WIDTH-1:0]       res_p3_d, res_p3_q;
  logic                        ovf_p3_d, ovf_p3_q;
  logic                        vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, vld_p3_d, vld_p3_q;
  logic [DATA_WIDTH-1:0]       buf_d [OUT_DEPTH];
  logic [DATA_WIDTH-1:0]       buf_q [OUT_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]            count_d, count_q;
  logic                        ovf_d, ovf_q;
  logic [CNT_W+1:0]            credit_used;
  logic                        push, pop;

  // Issue gate: only pop upstream when a buffer slot is guaranteed for the result.
  always_comb begin
    credit_used = (CNT_W+2)'(count_q) + (CNT_W+2)'(vld_p1_q) +
                  (CNT_W+2)'(vld_p2_q) + (CNT_W+2)'(vld_p3_q);
    in_rd_en    = !in_empty && (credit_used < (CNT_W+2)'(OUT_DEPTH));
  end

  // ---- stage 1: element-wise products of the issued pair ----
  // Form the full-precision signed products.
  always_comb begin
    vld_p1_d = in_rd_en;
    for (int i = 0; i < VEC_LEN; i++)
      prod_p1_d[i] = PROD_W'($signed(x[i])) * PROD_W'($signed(y[i]));
  end

  // ---- stage 2: reduction of the products ----
  // Sum all products with enough guard bits that the sum cannot overflow.
  always_comb begin
    vld_p2_d = vld_p1_q;
    sum_p2_d = '0;
    for (int i = 0; i < VEC_LEN; i++)
      sum_p2_d = sum_p2_d + SUM_W'(prod_p1_q[i]);
  end

  // ---- stage 3: rescale and fit to the output width ----
  // Round/shift, then saturate or wrap, flagging any range overflow.
  always_comb begin
    vld_p3_d = vld_p2_q;
    acc_p3   = round_shift(sum_p2_q);
    res_p3_d = fit_result(acc_p3);
    ovf_p3_d = out_of_range(acc_p3);
  end

  // ---- output buffer: stage 3 result is pushed on the following edge ----
  // Circular FWFT buffer update plus the sticky overflow flag (set beats clear).
  always_comb begin
    push     = vld_p3_q;
    pop      = out_rd_en && !out_empty;
    buf_d    = buf_q;
    if (push) buf_d[wr_ptr_q] = res_p3_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d    = (push && ovf_p3_q) || (ovf_q && !clear_ovf);
  end

  // Datapath registers carry no reset; their valids decide whether they matter.
  always_ff @(posedge clock) begin
    prod_p1_q <= prod_p1_d;
    sum_p2_q  <= sum_p2_d;
    res_p3_q  <= res_p3_d;
    ovf_p3_q  <= ovf_p3_d;
    buf_q     <= buf_d;
  end

  // Control state: valids, pointers, occupancy and the sticky flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Head is forced to zero while empty so stale buffer contents never show.
  assign out_empty = (count_q == '0);
  assign out       = out_empty ? '0 : buf_q[rd_ptr_q];
  assign out_count = count_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dot_vec_pipe.sv
// Bench for dot_vec_pipe: two instances (truncate+saturate, round+wrap) share stimulus.
// An upstream queue feeds both; expected results are queued at issue, popped at output.
module tb_dot_vec_pipe;
  localparam int N = 3, DW = 32, Q = 10, DEPTH = 4, CW = $clog2(DEPTH) + 1;
  typedef logic [N-1:0][DW-1:0] vec_t;

  logic clock = 1'b0, reset = 1'b0;
  vec_t x = '0, y = '0;
  logic in_empty = 1'b1, out_rd_en = 1'b0, clear_ovf = 1'b0;
  logic in_rd_en_a, in_rd_en_b, out_empty_a, out_empty_b, ovf_a, ovf_b;
  logic [DW-1:0] out_a, out_b;
  logic [CW-1:0] out_count_a, out_count_b;

  dot_vec_pipe #(.VEC_LEN(N), .DATA_WIDTH(DW), .Q_BITS(Q), .OUT_DEPTH(DEPTH),
                 .ROUND(0), .SATURATE(1)) dut_a (
    .clock(clock), .reset(reset), .x(x), .y(y), .in_empty(in_empty), .in_rd_en(in_rd_en_a),
    .out(out_a), .out_empty(out_empty_a), .out_rd_en(out_rd_en), .out_count(out_count_a),
    .clear_ovf(clear_ovf), .ovf(ovf_a));

  dot_vec_pipe #(.VEC_LEN(N), .DATA_WIDTH(DW), .Q_BITS(Q), .OUT_DEPTH(DEPTH),
                 .ROUND(1), .SATURATE(0)) dut_b (
    .clock(clock), .reset(reset), .x(x), .y(y), .in_empty(in_empty), .in_rd_en(in_rd_en_b),
    .out(out_b), .out_empty(out_empty_b), .out_rd_en(out_rd_en), .out_count(out_count_b),
    .clear_ovf(clear_ovf), .ovf(ovf_b));

  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  int cyc = 0, last_cons = 0;
  bit lat_chk = 0;
  bit prev_empty = 1;
  vec_t src_x[$], src_y[$];
  logic [DW-1:0] exp_a[$], exp_b[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact dot product in wide integer arithmetic, then scale and fit.
  function automatic logic [DW-1:0] ref_dot(vec_t a, vec_t b, bit rnd, bit sat);
    logic signed [127:0] acc, sh, mx, mn;
    acc = '0;
    for (int i = 0; i < N; i++)
      acc = acc + 128'($signed(a[i])) * 128'($signed(b[i]));
    if (rnd) acc = acc + 128'(2 ** (Q - 1));
    sh = acc >>> Q;
    mx = 128'(32'h7FFF_FFFF);
    mn = -mx - 128'(1);
    if (sat && sh > mx) return 32'h7FFF_FFFF;
    if (sat && sh < mn) return 32'h8000_0000;
    return sh[DW-1:0];
  endfunction

  function automatic vec_t mk(logic [DW-1:0] a0, logic [DW-1:0] a1, logic [DW-1:0] a2);
    vec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2;
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_elem();
    logic [DW-1:0] r;
    if ($urandom_range(3) == 0) r = $urandom;
    else r = DW'($signed(17'($urandom)));
    return r;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Upstream FWFT model: pops the head when the DUT took it, presents the next head.
  always @(posedge clock) begin : drv
    bit took;
    vec_t a, b;
    took = reset && in_rd_en_a;
    #2;
    if (took) begin
      if (src_x.size() == 0) begin
        tests++; fails++;
        $display("FAIL pop_empty_source: in_rd_en 1, required 0 with no data");
      end else begin
        a = src_x.pop_front();
        b = src_y.pop_front();
        exp_a.push_back(ref_dot(a, b, 1'b0, 1'b1));
        exp_b.push_back(ref_dot(a, b, 1'b1, 1'b0));
        last_cons = cyc;
      end
    end
    in_empty = (src_x.size() == 0);
    if (!in_empty) begin
      x = src_x[0];
      y = src_y[0];
    end
  end

  // Monitor: compares every popped head against the scoreboard, plus structural checks.
  always @(negedge clock) begin : mon
    logic [DW-1:0] e;
    if (reset) begin
      check("in_rd_en_agree", in_rd_en_b, in_rd_en_a);
      check("out_empty_agree", out_empty_b, out_empty_a);
      check("count_le_depth", 64'(out_count_a <= DEPTH), 64'd1);
      if (lat_chk && prev_empty && !out_empty_a)
        check("latency", 64'(cyc - last_cons), 64'd3);
      prev_empty = out_empty_a;
      if (!out_empty_a && out_rd_en) begin
        if (exp_a.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out_a: got 0x%0h, required no output", out_a);
        end else begin
          e = exp_a.pop_front();
          check("out_a", out_a, e);
        end
      end
      if (!out_empty_b && out_rd_en) begin
        if (exp_b.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out_b: got 0x%0h, required no output", out_b);
        end else begin
          e = exp_b.pop_front();
          check("out_b", out_b, e);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clock); #3; end
  endtask

  task automatic push(vec_t a, vec_t b);
    src_x.push_back(a);
    src_y.push_back(b);
  endtask

  task automatic drain(int budget);
    int n = 0;
    out_rd_en = 1'b1;
    while ((src_x.size() != 0 || exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results left, required 0", exp_a.size());
    end
    step(1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    step(2);
    check("rst_out_empty", out_empty_a, 1);
    check("rst_out_count", out_count_a, 0);
    check("rst_out", out_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_in_rd_en", in_rd_en_a, 0);
    reset = 1'b1;
    step(1);

    // Directed single vectors, each into an idle pipe so latency is observable.
    lat_chk = 1;
    push(mk(32'h400, 32'h800, 32'hC00), mk(32'h400, 32'h400, 32'h400));
    drain(20);
    push(mk(32'hFFFF_FC00, 0, 0), mk(32'h200, 0, 0));
    drain(20);
    push(mk(32'h1, 0, 0), mk(32'h200, 0, 0));
    drain(20);
    push(mk(32'hFFFF_FFFF, 0, 0), mk(32'h200, 0, 0));
    drain(20);
    check("ovf_a_clean", ovf_a, 0);
    check("ovf_b_clean", ovf_b, 0);
    push(mk(32'h7FFF_FFFF, 0, 0), mk(32'h7FFF_FFFF, 0, 0));
    drain(20);
    check("ovf_a_set", ovf_a, 1);
    check("ovf_b_set", ovf_b, 1);
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    check("ovf_a_cleared", ovf_a, 0);
    check("ovf_b_cleared", ovf_b, 0);
    lat_chk = 0;

    // Backpressure: only DEPTH pairs may be accepted while nothing drains.
    out_rd_en = 1'b0;
    for (int i = 0; i < 10; i++) push(mk(rnd_elem(), rnd_elem(), rnd_elem()),
                                      mk(rnd_elem(), rnd_elem(), rnd_elem()));
    step(15);
    check("bp_consumed", 64'(10 - src_x.size()), 64'd4);
    check("bp_count", out_count_a, DEPTH);
    check("bp_in_rd_en", in_rd_en_a, 0);
    check("bp_not_empty", out_empty_a, 0);
    drain(200);

    // Asynchronous reset with results both in flight and buffered.
    out_rd_en = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(rnd_elem(), rnd_elem(), rnd_elem()),
                                     mk(rnd_elem(), rnd_elem(), rnd_elem()));
    n = 0;
    while (out_count_a != 2 && n < 20) begin step(1); n++; end
    check("pre_reset_count", out_count_a, 2);
    #1 reset = 1'b0;
    #1;
    check("async_rst_empty", out_empty_a, 1);
    check("async_rst_count", out_count_a, 0);
    check("async_rst_count_b", out_count_b, 0);
    exp_a.delete();
    exp_b.delete();
    src_x.delete();
    src_y.delete();
    step(2);
    reset = 1'b1;
    step(1);
    lat_chk = 1;
    push(mk(32'h400, 32'h800, 32'hC00), mk(32'h400, 32'h400, 32'h400));
    drain(20);
    lat_chk = 0;

    // Randomized traffic with upstream gaps and random downstream stalls.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) != 0)
        push(mk(rnd_elem(), rnd_elem(), rnd_elem()), mk(rnd_elem(), rnd_elem(), rnd_elem()));
      out_rd_en = 1'($urandom_range(1));
      step(1);
    end
    drain(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
